// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one external combinational ALU
//               between two requesters. The grantee's operands are
//               registered onto the ALU drive, and the ALU result and zero
//               flag are captured into that port's result registers. A done
//               pulse then qualifies the new result.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               reqN, aN, bN, ctrlN   - port N request and operation
//               doneN, resN, zeroN    - port N completion pulse and results
//               alu_a, alu_b, alu_ctrl- registered drive to the external ALU
//               alu_out, alu_zero     - result from the external ALU
//               busy                  - an operation is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [WIDTH-1:0]  a0,
    input  logic [WIDTH-1:0]  b0,
    input  logic [CTRL_W-1:0] ctrl0,
    output logic              done0,
    output logic [WIDTH-1:0]  res0,
    output logic              zero0,
    input  logic              req1,
    input  logic [WIDTH-1:0]  a1,
    input  logic [WIDTH-1:0]  b1,
    input  logic [CTRL_W-1:0] ctrl1,
    output logic              done1,
    output logic [WIDTH-1:0]  res1,
    output logic              zero1,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_zero,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_gnt;
    logic               r_last_gnt;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [CTRL_W-1:0]  r_alu_ctrl;
    logic [WIDTH-1:0]   r_res0;
    logic [WIDTH-1:0]   r_res1;
    logic               r_zero0;
    logic               r_zero1;

    logic               w_any_req;
    logic               w_pick;
    logic               w_grant;
    logic               w_capture;
    logic               w_busy;
    logic               w_done0;
    logic               w_done1;

    // Single request wins outright; on a tie the port not served last wins.
    assign w_any_req = req0 | req1;
    assign w_pick    = (req0 & req1) ? ~r_last_gnt : req1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and FSM outputs
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        w_busy      = 1'b1;
        w_done0     = 1'b0;
        w_done1     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_any_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                // Requests are deliberately not looked at here.
                w_done0     = ~r_gnt;
                w_done1     = r_gnt;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand latch at grant, result capture at end of EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= '0;
            r_res0     <= '0;
            r_res1     <= '0;
            r_zero0    <= 1'b0;
            r_zero1    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_gnt      <= w_pick;
                r_alu_a    <= w_pick ? a1    : a0;
                r_alu_b    <= w_pick ? b1    : b0;
                r_alu_ctrl <= w_pick ? ctrl1 : ctrl0;
            end
            if (w_capture) begin
                r_last_gnt <= r_gnt;
                if (r_gnt) begin
                    r_res1  <= alu_out;
                    r_zero1 <= alu_zero;
                end else begin
                    r_res0  <= alu_out;
                    r_zero0 <= alu_zero;
                end
            end
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_ctrl = r_alu_ctrl;
    assign res0     = r_res0;
    assign res1     = r_res1;
    assign zero0    = r_zero0;
    assign zero1    = r_zero1;
    assign done0    = w_done0;
    assign done1    = w_done1;
    assign busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. A behavioural ALU sits on
//               the ALU drive; a transaction-level model (grant edge plus
//               fixed latency) predicts every output after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  ctrl0, ctrl1;
    logic        done0, done1, zero0, zero1, busy;
    logic [31:0] res0, res1;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0), .ctrl0(ctrl0),
        .done0(done0), .res0(res0), .zero0(zero0),
        .req1(req1), .a1(a1), .b1(b1), .ctrl1(ctrl1),
        .done1(done1), .res1(res1), .zero1(zero1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
    );

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
        case (c)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a | b;
            4'b0011: return a ^ b;
            4'b1101: return a & b;
            default: return a ^ {b[15:0], b[31:16]};
        endcase
    endfunction

    assign alu_out  = alu_fn(alu_a, alu_b, alu_ctrl);
    assign alu_zero = (alu_out == 32'd0);

    // Transaction-level model: an operation granted at edge g drives the ALU
    // from g on, completes at edge g+1 (done visible right after it), and the
    // arbiter accepts a new request from edge g+3 on.
    bit          m_have;
    int          m_gedge;
    bit          m_g;
    bit          m_last;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_ctrl;
    logic [31:0] m_res [2];
    bit          m_zero [2];
    int          done_seen [2];

    task automatic model_edge(input int n);
        if (reset) begin
            m_have = 0; m_last = 1;
            m_a = 0; m_b = 0; m_ctrl = 0;
            m_res[0] = 0; m_res[1] = 0; m_zero[0] = 0; m_zero[1] = 0;
        end else begin
            if (m_have && n == m_gedge + 1) begin
                m_res[m_g]  = alu_fn(m_a, m_b, m_ctrl);
                m_zero[m_g] = (m_res[m_g] == 32'd0);
                m_last      = m_g;
            end
            if ((!m_have || n >= m_gedge + 3) && (req0 || req1)) begin
                m_g     = (req0 && req1) ? !m_last : req1;
                m_a     = m_g ? a1 : a0;
                m_b     = m_g ? b1 : b0;
                m_ctrl  = m_g ? ctrl1 : ctrl0;
                m_have  = 1;
                m_gedge = n;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        bit in_flight;
        in_flight = m_have && (cyc <= m_gedge + 1);
        chk("busy",     {31'd0, busy},  {31'd0, in_flight});
        chk("done0",    {31'd0, done0}, {31'd0, in_flight && cyc == m_gedge + 1 && !m_g});
        chk("done1",    {31'd0, done1}, {31'd0, in_flight && cyc == m_gedge + 1 && m_g});
        chk("alu_a",    alu_a, m_a);
        chk("alu_b",    alu_b, m_b);
        chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, m_ctrl});
        chk("res0",     res0, m_res[0]);
        chk("res1",     res1, m_res[1]);
        chk("zero0",    {31'd0, zero0}, {31'd0, m_zero[0]});
        chk("zero1",    {31'd0, zero1}, {31'd0, m_zero[1]});
        if (done0) done_seen[0]++;
        if (done1) done_seen[1]++;
    endtask

    // Model and DUT both see the inputs held across the coming edge; outputs
    // are sampled 1 time unit after it.
    task automatic step();
        model_edge(cyc + 1);
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    initial begin
        bit          exp_port;
        logic [31:0] ra;
        reset = 1; req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; ctrl0 = 0; a1 = 0; b1 = 0; ctrl1 = 0;
        done_seen[0] = 0; done_seen[1] = 0;

        // Reset state
        step(); step();
        reset = 0;
        step();

        // Single request on port 0
        req0 = 1; a0 = 32'h0000F054; b0 = 32'h0000005F; ctrl0 = 4'b0000;
        step();                                  // grant edge
        chk("tp_drive_a", alu_a, 32'h0000F054);
        req0 = 0;
        step();                                  // RESP cycle
        chk("tp_done0", {31'd0, done0}, 32'd1);
        chk("tp_res0",  res0, 32'h0000F0B3);
        chk("tp_res1",  res1, 32'd0);
        step(); step();

        // Zero flag on port 1
        req1 = 1; a1 = 32'h00000000; b1 = 32'h00000001; ctrl1 = 4'b1101;
        step();
        req1 = 0;
        step();
        chk("tp_done1", {31'd0, done1}, 32'd1);
        chk("tp_zero1", {31'd0, zero1}, 32'd1);
        chk("tp_zero0_kept", {31'd0, zero0}, 32'd0);
        step();

        // Contention from reset: grants must alternate starting with port 0
        reset = 1; step(); reset = 0;
        req0 = 1; req1 = 1; exp_port = 0;
        for (int i = 0; i < 18; i++) begin
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            ctrl0 = 4'($urandom_range(0, 3)); ctrl1 = 4'($urandom_range(0, 3));
            step();
            if (done0 || done1) begin
                chk("contention_order", {31'd0, done1}, {31'd0, exp_port});
                exp_port = !exp_port;
            end
        end
        req0 = 0; req1 = 0;
        step(); step(); step();

        // Operand change after grant
        req0 = 1; a0 = 32'h12345678; b0 = 32'h00000008; ctrl0 = 4'b0001;
        step();
        a0 = 32'hFFFFFFFF; req0 = 0;
        step();
        chk("tp_hold_a", alu_a, 32'h12345678);
        chk("tp_old_res", res0, 32'h12345670);
        step();

        // Reset while in EXEC aborts the operation, then a tie goes to port 0
        req1 = 1; a1 = 32'h00000055; b1 = 32'h00000011; ctrl1 = 4'b0000;
        step();
        req1 = 0; reset = 1;
        step();
        reset = 0;
        chk("tp_abort_busy", {31'd0, busy}, 32'd0);
        chk("tp_abort_res1", res1, 32'd0);
        req0 = 1; req1 = 1; a0 = 32'h0000AAAA; a1 = 32'h0000BBBB;
        step();
        chk("tp_tie_port0", alu_a, 32'h0000AAAA);
        req0 = 0; req1 = 0;
        step(); step();

        // Request withdrawn during EXEC still completes, then stays idle
        req0 = 1; a0 = $urandom; b0 = $urandom; ctrl0 = 4'b0011;
        step();
        req0 = 0;
        step();
        chk("tp_wd_done0", {31'd0, done0}, 32'd1);
        step(); step(); step();
        chk("tp_wd_idle", {31'd0, busy}, 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            req0  = ($urandom_range(0, 9) < 6);
            req1  = ($urandom_range(0, 9) < 6);
            ra    = $urandom;
            a0 = ($urandom_range(0, 3) == 0) ? 32'd0 : ra;
            b0 = $urandom; ctrl0 = 4'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            b1 = $urandom; ctrl1 = 4'($urandom);
            step();
        end
        reset = 0; req0 = 0; req1 = 0;
        step(); step(); step();
        chk("saw_done0", {31'd0, done_seen[0] > 5}, 32'd1);
        chk("saw_done1", {31'd0, done_seen[1] > 5}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
